// File: rtl/transmit_packet.sv
// -----------------------------------------------------------------------------
// transmit_packet
//
// Builds one 288-bit lasernet transmit packet (nine 32-bit octets) from the
// connection state machine's header fields and one 128-bit slice of the
// outgoing 640-bit message. The 16-bit one's-complement checksum is summed
// serially, one 16-bit word per cycle, and then folded. The finished packet is
// registered together with a single-cycle done pulse.
//
// Build timeline (E0 = accept edge):
//   E0       IDLE -> SUM, latch seq/ack/flags/data, cnt=0, sum=0
//   E1..E18  add word[cnt] (cnt = 0..17), E18 moves to FOLD
//   E19      fold, load packet, done<=1, back to IDLE
//
// Handshake: start is a level request sampled on each rising edge. It is
// accepted only when the FSM is in IDLE (busy=0); a start seen while busy is
// dropped, not queued. done is high for exactly one cycle per accepted build,
// and packet is stable outside the cycle that follows a FOLD edge.
//
// Ports:
//   clk      in   1    system clock
//   reset    in   1    asynchronous, active-high reset
//   start    in   1    build request, honoured only in IDLE
//   isn      in   32   initial sequence number of the connection
//   seq      in   32   sequence number to send
//   ack      in   32   acknowledgement number to send
//   flags    in   9    TCP flags
//   message  in   640  outgoing message, part k = message[128*k-1 : 128*(k-1)]
//   busy     out  1    build in progress (SUM or FOLD)
//   done     out  1    one-cycle pulse, packet just updated
//   packet   out  288  {octet1..octet9}, octet1 in [287:256]
// -----------------------------------------------------------------------------
module transmit_packet #(
    parameter logic [15:0] SRC_PORT = 16'd1111,
    parameter logic [15:0] DST_PORT = 16'd2222,
    parameter logic [15:0] WINDOW   = 16'd5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [31:0]  isn,
    input  logic [31:0]  seq,
    input  logic [31:0]  ack,
    input  logic [8:0]   flags,
    input  logic [639:0] message,
    output logic         busy,
    output logic         done,
    output logic [287:0] packet
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SUM  = 2'b01,
        ST_FOLD = 2'b10,
        ST_BAD  = 2'b11
    } state_t;

    // State register kept as plain bits so the unused code can be reached
    // and observed from outside the FSM.
    logic [1:0]   r_state;
    state_t       w_next;

    logic         w_accept;
    logic         w_add;
    logic         w_fold;

    logic [4:0]   r_cnt;
    logic [20:0]  r_sum;
    logic [31:0]  r_seq;
    logic [31:0]  r_ack;
    logic [8:0]   r_flags;
    logic [127:0] r_data;
    logic [287:0] r_packet;
    logic         r_done;

    logic [31:0]  w_off;
    logic [127:0] w_sel_data;
    logic [287:0] w_words;
    logic [8:0]   w_lsb;
    logic [287:0] w_shift;
    logic [15:0]  w_word;
    logic [16:0]  w_s1;
    logic [15:0]  w_s2;
    logic [15:0]  w_csum;

    // ------------------------------------------------------------------
    // Data slice selection: offset of this segment within the message.
    // Offset 0 and anything past part 5 (including wrapped values) is a
    // control packet with an all-zero payload.
    // ------------------------------------------------------------------
    assign w_off = seq - isn;

    always_comb begin
        w_sel_data = 128'b0;
        case (w_off)
            32'd1:   w_sel_data = message[127:0];
            32'd2:   w_sel_data = message[255:128];
            32'd3:   w_sel_data = message[383:256];
            32'd4:   w_sel_data = message[511:384];
            32'd5:   w_sel_data = message[639:512];
            default: w_sel_data = 128'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Word stream for the checksum: the packet image with the checksum
    // field zero. word[cnt] sits at bit 272 - 16*cnt.
    // ------------------------------------------------------------------
    assign w_words = {SRC_PORT, DST_PORT, r_seq, r_ack, 7'b0, r_flags, WINDOW,
                      32'h0000_0000, r_data};
    assign w_lsb   = 9'd272 - {r_cnt, 4'b0000};
    assign w_shift = w_words >> w_lsb;
    assign w_word  = w_shift[15:0];

    // Two end-around-carry folds are enough: 18 words fit in 21 bits, and
    // after the first fold a carry out leaves a tiny low half.
    assign w_s1   = {1'b0, r_sum[15:0]} + {12'b0, r_sum[20:16]};
    assign w_s2   = w_s1[15:0] + {15'b0, w_s1[16]};
    assign w_csum = ~w_s2;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = ST_IDLE;
        w_accept = 1'b0;
        w_add    = 1'b0;
        w_fold   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = ST_SUM;
                end
            end
            ST_SUM: begin
                w_add  = 1'b1;
                w_next = (r_cnt == 5'd17) ? ST_FOLD : ST_SUM;
            end
            ST_FOLD: begin
                w_fold = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= 5'd0;
            r_sum    <= 21'd0;
            r_seq    <= 32'd0;
            r_ack    <= 32'd0;
            r_flags  <= 9'd0;
            r_data   <= 128'b0;
            r_packet <= 288'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_fold;
            if (w_accept) begin
                r_seq   <= seq;
                r_ack   <= ack;
                r_flags <= flags;
                r_data  <= w_sel_data;
                r_cnt   <= 5'd0;
                r_sum   <= 21'd0;
            end
            if (w_add) begin
                r_sum <= r_sum + {5'b0, w_word};
                r_cnt <= r_cnt + 5'd1;
            end
            if (w_fold) begin
                r_packet <= {SRC_PORT, DST_PORT, r_seq, r_ack, 7'b0, r_flags,
                             WINDOW, w_csum, 16'h0000, r_data};
            end
        end
    end

    assign busy   = (r_state == ST_SUM) || (r_state == ST_FOLD);
    assign done   = r_done;
    assign packet = r_packet;

endmodule

// File: tb/tb_transmit_packet.sv
// -----------------------------------------------------------------------------
// tb_transmit_packet
//
// Directed and table-driven stimulus for transmit_packet. Each accepted build
// pushes its expected packet and expected done cycle; a negedge monitor pops
// them whenever done is seen and also re-verifies the checksum of the packet
// the way the receive side does.
// -----------------------------------------------------------------------------
module tb_transmit_packet;

    localparam logic [15:0] SRC_PORT = 16'd1111;
    localparam logic [15:0] DST_PORT = 16'd2222;
    localparam logic [15:0] WINDOW   = 16'd5;

    logic         clk;
    logic         reset;
    logic         start;
    logic [31:0]  isn;
    logic [31:0]  seq;
    logic [31:0]  ack;
    logic [8:0]   flags;
    logic [639:0] message;
    logic         busy;
    logic         done;
    logic [287:0] packet;

    int           cyc;
    int           n_checks;
    int           n_errors;
    logic [287:0] exp_q[$];
    int           exp_cyc_q[$];
    logic [287:0] last_pkt;

    transmit_packet #(
        .SRC_PORT (SRC_PORT),
        .DST_PORT (DST_PORT),
        .WINDOW   (WINDOW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .isn     (isn),
        .seq     (seq),
        .ack     (ack),
        .flags   (flags),
        .message (message),
        .busy    (busy),
        .done    (done),
        .packet  (packet)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] fold_sum(input logic [287:0] p);
        int unsigned s;
        logic [287:0] t;
        s = 0;
        for (int k = 0; k < 18; k++) begin
            t = p >> (16 * (17 - k));
            s = s + t[15:0];
        end
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        return s[15:0];
    endfunction

    function automatic logic [287:0] model(input logic [31:0] m_isn, input logic [31:0] m_seq,
                                           input logic [31:0] m_ack, input logic [8:0] m_flags,
                                           input logic [639:0] m_msg);
        logic [31:0]  off;
        logic [127:0] d;
        logic [287:0] p;
        logic [15:0]  s;
        off = m_seq - m_isn;
        d   = '0;
        if (off >= 1 && off <= 5) d = m_msg[(off - 1) * 128 +: 128];
        p = {SRC_PORT, DST_PORT, m_seq, m_ack, 7'b0, m_flags, WINDOW, 32'h0, d};
        s = fold_sum(p);
        p[159:144] = ~s;
        return p;
    endfunction

    function automatic logic [639:0] rand_msg();
        logic [639:0] m;
        for (int i = 0; i < 20; i++) m[i * 32 +: 32] = $urandom();
        return m;
    endfunction

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a negedge with the DUT idle. Returns at the negedge where the
    // build's done is visible, so the next call is a back-to-back accept.
    task automatic build(input logic [31:0] t_isn, input logic [31:0] t_seq,
                         input logic [31:0] t_ack, input logic [8:0] t_flags,
                         input logic [639:0] t_msg, input logic [287:0] t_exp);
        isn     = t_isn;
        seq     = t_seq;
        ack     = t_ack;
        flags   = t_flags;
        message = t_msg;
        start   = 1'b1;
        exp_q.push_back(t_exp);
        exp_cyc_q.push_back(cyc + 1 + 19);
        last_pkt = t_exp;
        @(negedge clk);
        start = 1'b0;
        // Scramble inputs mid-build: only the latched copies may matter.
        isn     = t_isn + 32'd1;
        seq     = ~t_seq;
        ack     = ~t_ack;
        flags   = ~t_flags;
        message = ~t_msg;
        repeat (19) @(negedge clk);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got done at cycle %0d, required no done", cyc);
            end else begin
                logic [287:0] e;
                int           ec;
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                n_checks++;
                if (cyc != ec) begin
                    n_errors++;
                    $display("FAIL done_cycle: got %0d, required %0d", cyc, ec);
                end
                chk("packet", packet, e);
                n_checks++;
                if (fold_sum(packet) !== 16'hFFFF) begin
                    n_errors++;
                    $display("FAIL rx_checksum: got %h, required ffff", fold_sum(packet));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] str;
        logic [639:0] m;
        logic [31:0]  r_isn;
        logic [31:0]  r_seq;
        logic [31:0]  r_ack;
        logic [8:0]   r_flags;
        int           acc;

        n_checks = 0;
        n_errors = 0;
        last_pkt = '0;
        reset    = 1'b1;
        start    = 1'b0;
        isn      = '0;
        seq      = '0;
        ack      = '0;
        flags    = '0;
        message  = '0;

        repeat (3) @(negedge clk);
        chk("reset_busy", {287'b0, busy}, 288'b0);
        chk("reset_done", {287'b0, done}, 288'b0);
        chk("reset_packet", packet, 288'b0);
        reset = 1'b0;
        @(negedge clk);

        // Control packet, fully hand-computed.
        build(32'd1, 32'd1, 32'd0, 9'h002, rand_msg(),
              {32'h045708AE, 32'h0000_0001, 32'h0000_0000, 32'h0002_0005,
               32'hF2F2_0000, 128'h0});

        // Wrapped offset 5 selects part 5.
        str = "ABCDEFGHIJKLMNOP";
        m = rand_msg();
        m[639:512] = str;
        build(32'hFFFF_FFFE, 32'd3, 32'h1234_5678, 9'h018, m,
              model(32'hFFFF_FFFE, 32'd3, 32'h1234_5678, 9'h018, m));
        chk("part5_data", {160'b0, packet[127:0]}, {160'b0, str});

        // Offset 6 is past the message: control packet.
        build(32'h0000_0100, 32'h0000_0106, 32'h0000_0042, 9'h010, m,
              model(32'h0000_0100, 32'h0000_0106, 32'h0000_0042, 9'h010, m));
        chk("off6_data", {160'b0, packet[127:0]}, 288'b0);

        // Offsets 1..4 each pick their own part.
        for (int k = 1; k <= 4; k++) begin
            m = rand_msg();
            build(32'h0000_5000, 32'h0000_5000 + k, 32'hA5A5_0000 + k, 9'h018, m,
                  model(32'h0000_5000, 32'h0000_5000 + k, 32'hA5A5_0000 + k, 9'h018, m));
        end

        // start held high: a build every 20 cycles, nothing queued in between.
        m = rand_msg();
        isn     = 32'd100;
        seq     = 32'd103;
        ack     = 32'hCAFE_0001;
        flags   = 9'h1FF;
        message = m;
        start   = 1'b1;
        acc = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(model(32'd100, 32'd103, 32'hCAFE_0001, 9'h1FF, m));
            exp_cyc_q.push_back(acc + 19 + 20 * i);
        end
        last_pkt = model(32'd100, 32'd103, 32'hCAFE_0001, 9'h1FF, m);
        repeat (41) @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);

        // Reset in the middle of SUM: no done, outputs clear at once.
        @(negedge clk);
        m = rand_msg();
        isn = 32'd7; seq = 32'd9; ack = 32'd1; flags = 9'h018; message = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_reset_busy", {287'b0, busy}, {287'b0, 1'b1});
        reset = 1'b1;
        #1;
        chk("mid_reset_busy", {287'b0, busy}, 288'b0);
        chk("mid_reset_done", {287'b0, done}, 288'b0);
        chk("mid_reset_packet", packet, 288'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        m = rand_msg();
        build(32'd7, 32'd9, 32'd1, 9'h018, m, model(32'd7, 32'd9, 32'd1, 9'h018, m));

        // Unused state code returns to IDLE silently.
        @(negedge clk);
        force dut.r_state = 2'b11;
        #1;
        chk("bad_state_busy", {287'b0, busy}, 288'b0);
        release dut.r_state;
        @(negedge clk);
        chk("bad_state_next", {286'b0, dut.r_state}, 288'b0);
        chk("bad_state_done", {287'b0, done}, 288'b0);
        chk("bad_state_packet", packet, last_pkt);

        // Random self-check sweep, offsets 0..7.
        for (int i = 0; i < 200; i++) begin
            r_isn   = $urandom();
            r_seq   = r_isn + $urandom_range(0, 7);
            r_ack   = $urandom();
            r_flags = 9'($urandom_range(0, 511));
            m       = rand_msg();
            build(r_isn, r_seq, r_ack, r_flags, m, model(r_isn, r_seq, r_ack, r_flags, m));
        end

        // Drain with a bounded wait.
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clk);
        while (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL missing_done: got no done, required done at cycle %0d", exp_cyc_q[0]);
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
